clk_div_multi: RTL and testbench

Parametrised multi-channel programmable clock divider. Each channel produces a registered, glitch-free divided clock (or strobe) from the single system clock. Divisor changes are shadowed and applied only at period boundaries, so there are no runt pulses. It sits in the clocking/timing subsystem and feeds peripheral baud/sample enables and low-rate derived clocks.

---
 rtl/clk_div_multi_if.sv | 27 ++
 rtl/clk_div_multi.sv | 116 +++++++++++
 tb/tb_clk_div_multi.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/clk_div_multi_if.sv
// Bundle of control and status signals between a controller and the
// multi-channel clock divider.
interface clk_div_multi_if #(
  parameter int N_CH  = 4,
  parameter int DIV_W = 16
);
  // No handshake: en and mode are levels. load is a one-cycle strobe and is
  // accepted on every cycle it is high. Outputs are registered in the divider.
  logic [N_CH-1:0]       en;
  logic [N_CH-1:0]       mode;
  logic [N_CH*DIV_W-1:0] div_value;
  logic [N_CH-1:0]       load;
  logic [N_CH-1:0]       clk_out;
  logic [N_CH-1:0]       tick;
  logic [N_CH-1:0]       pending;
  logic [N_CH-1:0]       dbg_state;

  modport master (
    output en, mode, div_value, load,
    input  clk_out, tick, pending, dbg_state
  );

  modport slave (
    input  en, mode, div_value, load,
    output clk_out, tick, pending, dbg_state
  );
endinterface

// File: rtl/clk_div_multi.sv
// Multi-channel programmable clock divider. Divisor updates are shadowed and
// applied only at period boundaries or while a channel is stopped.
module clk_div_multi #(
  parameter int N_CH    = 4,
  parameter int DIV_W   = 16,
  parameter int RST_DIV = 0
) (
  input  logic            clk,
  input  logic            rst_n,
  clk_div_multi_if.slave  bus
);

  localparam logic [0:0]       ST_STOP = 1'b0;
  localparam logic [0:0]       ST_RUN  = 1'b1;
  localparam logic [DIV_W-1:0] RST_ACT = DIV_W'(RST_DIV);

  // A stored divisor of 1 cannot produce a clock, so it runs as 2.
  function automatic logic [DIV_W-1:0] eff_div(input logic [DIV_W-1:0] d);
    return (d == DIV_W'(1)) ? DIV_W'(2) : d;
  endfunction

  logic [N_CH-1:0] clk_v;
  logic [N_CH-1:0] tick_v;
  logic [N_CH-1:0] pend_v;
  logic [N_CH-1:0] state_v;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic [DIV_W-1:0] cnt_q, cnt_nx;
    logic [DIV_W-1:0] act_q, act_nx;
    logic [DIV_W-1:0] pdiv_q, pdiv_nx;
    logic [DIV_W-1:0] eff_q, eff_nx;
    logic [DIV_W-1:0] dv;
    logic [0:0]       state_q, state_nx;
    logic             pend_q, pend_nx;
    logic             clk_q, clk_nx;
    logic             tick_q, tick_nx;
    logic             run_now;
    logic             last;
    logic             window;

    assign dv = bus.div_value[i*DIV_W +: DIV_W];

    // state_q says whether the cycle now on the outputs is a running cycle;
    // cnt_q is the position within the period of that same cycle.
    always_comb begin
      eff_q   = eff_div(act_q);
      run_now = bus.en[i] && (act_q != '0);
      last    = (state_q == ST_RUN) && (cnt_q == eff_q - DIV_W'(1));
      // Cycles where a new divisor may take over without creating a runt.
      window  = last || (state_q == ST_STOP) || !run_now;

      act_nx  = act_q;
      pdiv_nx = pdiv_q;
      pend_nx = pend_q;
      if (bus.load[i]) begin
        if (window) begin
          act_nx  = dv;
          pend_nx = 1'b0;
        end else begin
          pdiv_nx = dv;
          pend_nx = 1'b1;
        end
      end else if (pend_q && window) begin
        act_nx  = pdiv_q;
        pend_nx = 1'b0;
      end

      eff_nx   = eff_div(act_nx);
      state_nx = (bus.en[i] && (act_nx != '0)) ? ST_RUN : ST_STOP;

      if ((state_nx == ST_STOP) || window) begin
        cnt_nx = '0;
      end else begin
        cnt_nx = cnt_q + DIV_W'(1);
      end

      clk_nx  = 1'b0;
      tick_nx = 1'b0;
      if (state_nx == ST_RUN) begin
        tick_nx = (cnt_nx == '0);
        clk_nx  = bus.mode[i] ? (cnt_nx == '0) : (cnt_nx < (eff_nx >> 1));
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt_q   <= '0;
        act_q   <= RST_ACT;
        pdiv_q  <= '0;
        pend_q  <= 1'b0;
        state_q <= ST_STOP;
        clk_q   <= 1'b0;
        tick_q  <= 1'b0;
      end else begin
        cnt_q   <= cnt_nx;
        act_q   <= act_nx;
        pdiv_q  <= pdiv_nx;
        pend_q  <= pend_nx;
        state_q <= state_nx;
        clk_q   <= clk_nx;
        tick_q  <= tick_nx;
      end
    end

    assign clk_v[i]   = clk_q;
    assign tick_v[i]  = tick_q;
    assign pend_v[i]  = pend_q;
    assign state_v[i] = state_q[0];
  end

  assign bus.clk_out   = clk_v;
  assign bus.tick      = tick_v;
  assign bus.pending   = pend_v;
  assign bus.dbg_state = state_v;

endmodule

// File: tb/tb_clk_div_multi.sv
// Directed bench for clk_div_multi: divide patterns, shadowed loads,
// mode switching, enable drop/restart and asynchronous reset.
module tb_clk_div_multi;
  localparam int N_CH  = 4;
  localparam int DIV_W = 16;

  logic clk;
  logic rst_n;
  int   n_pass;
  int   n_checks;

  clk_div_multi_if #(.N_CH(N_CH), .DIV_W(DIV_W)) bus ();

  clk_div_multi #(.N_CH(N_CH), .DIV_W(DIV_W), .RST_DIV(0)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_div(input int ch, input logic [DIV_W-1:0] v);
    bus.div_value[ch*DIV_W +: DIV_W] = v;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Expected waveforms, bit c = output cycle c after enabling.
  logic [11:0] e0_clk, e0_tick, e1_clk, e1_tick, e2_clk, e3_clk;
  logic [5:0]  e_pulse;

  initial begin
    n_pass = 0;
    n_checks = 0;
    e0_clk  = 12'b001100110011;
    e0_tick = 12'b000100010001;
    e1_clk  = 12'b110001100011;
    e1_tick = 12'b010000100001;
    e2_clk  = 12'b010101010101;
    e3_clk  = 12'b000100010001;
    e_pulse = 6'b001001;

    rst_n = 1'b0;
    bus.en = '0;
    bus.mode = '0;
    bus.load = '0;
    bus.div_value = '0;
    step(3);
    rst_n = 1'b1;
    step();
    check("rst_clk", 32'(bus.clk_out), 32'h0);
    check("rst_tick", 32'(bus.tick), 32'h0);
    check("rst_pend", 32'(bus.pending), 32'h0);

    // Enabled with a zero divisor stays stopped.
    bus.en = 4'hF;
    step(2);
    check("nodiv_clk", 32'(bus.clk_out), 32'h0);
    check("nodiv_tick", 32'(bus.tick), 32'h0);
    bus.en = '0;

    // D=4, 5, 1(->2) in clock mode, D=4 in pulse mode on ch3.
    set_div(0, 16'd4);
    set_div(1, 16'd5);
    set_div(2, 16'd1);
    set_div(3, 16'd4);
    bus.mode = 4'b1000;
    bus.load = 4'hF;
    step();
    bus.load = '0;
    bus.en = 4'hF;
    step();
    for (int c = 0; c < 12; c++) begin
      check($sformatf("div_clk_c%0d", c), 32'(bus.clk_out),
            32'({e3_clk[c], e2_clk[c], e1_clk[c], e0_clk[c]}));
      check($sformatf("div_tick_c%0d", c), 32'(bus.tick),
            32'({e3_clk[c], e2_clk[c], e1_tick[c], e0_tick[c]}));
      step();
    end
    bus.en = '0;
    step();
    check("stop_clk", 32'(bus.clk_out), 32'h0);
    check("stop_tick", 32'(bus.tick), 32'h0);

    // ch0 D=6, shadowed change to 3 at cnt=2.
    bus.mode = '0;
    set_div(0, 16'd6);
    bus.load = 4'b0001;
    step();
    bus.load = '0;
    bus.en = 4'b0001;
    step(3);
    set_div(0, 16'd3);
    bus.load = 4'b0001;
    step();
    bus.load = '0;
    check("sh_c3_pend", 32'(bus.pending[0]), 32'h1);
    check("sh_c3_clk", 32'(bus.clk_out[0]), 32'h0);
    step();
    check("sh_c4_pend", 32'(bus.pending[0]), 32'h1);
    step();
    check("sh_c5_clk", 32'(bus.clk_out[0]), 32'h0);
    check("sh_c5_tick", 32'(bus.tick[0]), 32'h0);
    check("sh_c5_pend", 32'(bus.pending[0]), 32'h1);
    step();
    check("sh_new0_clk", 32'(bus.clk_out[0]), 32'h1);
    check("sh_new0_tick", 32'(bus.tick[0]), 32'h1);
    check("sh_new0_pend", 32'(bus.pending[0]), 32'h0);
    step();
    check("sh_new1_clk", 32'(bus.clk_out[0]), 32'h0);
    step();
    check("sh_new2_clk", 32'(bus.clk_out[0]), 32'h0);
    check("sh_new2_tick", 32'(bus.tick[0]), 32'h0);
    step();
    check("sh_wrap_tick", 32'(bus.tick[0]), 32'h1);
    check("sh_wrap_clk", 32'(bus.clk_out[0]), 32'h1);

    // Two loads in one period: 8 then 10, last wins.
    set_div(0, 16'd8);
    bus.load = 4'b0001;
    step();
    check("ll_pend", 32'(bus.pending[0]), 32'h1);
    set_div(0, 16'd10);
    step();
    bus.load = '0;
    step();
    check("ll_c0_tick", 32'(bus.tick[0]), 32'h1);
    check("ll_c0_pend", 32'(bus.pending[0]), 32'h0);
    step(4);
    check("ll_c4_clk", 32'(bus.clk_out[0]), 32'h1);
    step(4);
    check("ll_c8_tick", 32'(bus.tick[0]), 32'h0);
    step(2);
    check("ll_c10_tick", 32'(bus.tick[0]), 32'h1);

    // Load on the boundary cycle bypasses the shadow.
    step(9);
    set_div(0, 16'd4);
    bus.load = 4'b0001;
    step();
    bus.load = '0;
    check("bp_pend", 32'(bus.pending[0]), 32'h0);
    check("bp_tick", 32'(bus.tick[0]), 32'h1);
    step(2);
    check("bp_c2_clk", 32'(bus.clk_out[0]), 32'h0);
    step(2);
    check("bp_c4_tick", 32'(bus.tick[0]), 32'h1);

    // Pulse mode D=3, then switch to clock mode mid-period.
    bus.en = '0;
    bus.mode = 4'b0001;
    set_div(0, 16'd3);
    bus.load = 4'b0001;
    step();
    bus.load = '0;
    check("pm_stop_clk", 32'(bus.clk_out[0]), 32'h0);
    bus.en = 4'b0001;
    step();
    for (int c = 0; c < 6; c++) begin
      check($sformatf("pm_clk_c%0d", c), 32'(bus.clk_out[0]), 32'(e_pulse[c]));
      step();
    end
    step();
    bus.mode = '0;
    step();
    check("ms_c2_clk", 32'(bus.clk_out[0]), 32'h0);
    step();
    check("ms_c0_clk", 32'(bus.clk_out[0]), 32'h1);
    step();
    check("ms_c1_clk", 32'(bus.clk_out[0]), 32'h0);

    // en dropped at cnt=2 of D=4, then restart from cnt=0.
    bus.en = '0;
    set_div(0, 16'd4);
    bus.load = 4'b0001;
    step();
    bus.load = '0;
    bus.en = 4'b0001;
    step(3);
    bus.en = '0;
    step();
    check("drop_clk", 32'(bus.clk_out[0]), 32'h0);
    check("drop_tick", 32'(bus.tick[0]), 32'h0);
    bus.en = 4'b0001;
    step();
    check("restart_clk", 32'(bus.clk_out[0]), 32'h1);
    check("restart_tick", 32'(bus.tick[0]), 32'h1);

    // Divisor 0 keeps the channel stopped; D=2 starts it at once.
    bus.en = '0;
    set_div(0, 16'd0);
    bus.load = 4'b0001;
    step();
    bus.load = '0;
    bus.en = 4'b0001;
    step();
    check("zero_clk", 32'(bus.clk_out[0]), 32'h0);
    check("zero_tick", 32'(bus.tick[0]), 32'h0);
    step();
    check("zero_clk2", 32'(bus.clk_out[0]), 32'h0);
    set_div(0, 16'd2);
    bus.load = 4'b0001;
    step();
    bus.load = '0;
    check("d2_c0_clk", 32'(bus.clk_out[0]), 32'h1);
    check("d2_c0_tick", 32'(bus.tick[0]), 32'h1);
    check("d2_c0_pend", 32'(bus.pending[0]), 32'h0);
    step();
    check("d2_c1_clk", 32'(bus.clk_out[0]), 32'h0);
    step();
    check("d2_c2_clk", 32'(bus.clk_out[0]), 32'h1);

    // Asynchronous reset in the middle of activity with a pending divisor.
    bus.en = 4'b0011;
    step(2);
    set_div(1, 16'd7);
    bus.load = 4'b0010;
    step();
    bus.load = '0;
    check("pre_rst_pend", 32'(bus.pending), 32'h2);
    rst_n = 1'b0;
    #1;
    check("arst_clk", 32'(bus.clk_out), 32'h0);
    check("arst_tick", 32'(bus.tick), 32'h0);
    check("arst_pend", 32'(bus.pending), 32'h0);
    step();
    rst_n = 1'b1;
    step(3);
    check("post_rst_clk", 32'(bus.clk_out), 32'h0);
    check("post_rst_tick", 32'(bus.tick), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
